// File: rtl/n_queen_solver.sv
// n_queen_solver
//   Backtracking N-queens search engine. One queen per row; col[r] holds the
//   column of the queen in row r. Each CHECK cycle compares row r against one
//   earlier row k. In mode 0 the first solution found is streamed out one
//   column per beat. In mode 1 the whole search space is explored and the
//   number of solutions is reported.
//
// Parameters
//   N   board size (1..16)
//   W   width of row/column indices
//   CW  width of the saturating solution counter
//
// Ports
//   clk        system clock, rising edge
//   user_reset asynchronous active-high reset; aborts any run
//   start      launches a run when sampled in IDLE
//   mode       latched with start: 0 = first solution + stream, 1 = count all
//   ready      high while IDLE
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of every run
//   found      at least one solution found in the last run
//   sol_count  solutions found in the last run (saturating)
//   out_valid  a solution beat is being offered
//   out_data   column of the queen in the row given by the beat number
//   out_ready  consumer accepts the beat when out_valid is also high
module n_queen_solver #(
    parameter int N  = 8,
    parameter int W  = (N < 2) ? 1 : $clog2(N),
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          user_reset,
    input  logic          start,
    input  logic          mode,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [CW-1:0] sol_count,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CHECK,
        ADVANCE,
        BACKTRACK,
        SOLVED,
        TRANSMIT,
        DONE
    } state_t;

    // The column store is sized to the full index range so every index is legal.
    localparam int         DEPTH = 2 ** W;
    localparam logic [W:0] LAST  = (W + 1)'(N - 1);

    state_t       state;
    logic [W-1:0] col [DEPTH];
    logic [W:0]   r;
    logic [W:0]   k;
    logic [W-1:0] b;
    logic         mode_q;

    logic [W-1:0] col_r;
    logic [W-1:0] col_k;
    logic [W:0]   row_dist;
    logic         conflict;

    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] c);
        logic signed [W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, c});
        return (d < 0) ? W'(-d) : W'(d);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    // Same column, or on a shared diagonal (column distance equals row distance).
    assign col_r    = col[r[W-1:0]];
    assign col_k    = col[k[W-1:0]];
    assign row_dist = r - k;
    assign conflict = (col_k == col_r) || ({1'b0, abs_diff(col_k, col_r)} == row_dist);

    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = (state == TRANSMIT);
    assign out_data  = (state == TRANSMIT) ? col[b] : '0;

    always_ff @(posedge clk or posedge user_reset) begin
        if (user_reset) begin
            state     <= IDLE;
            r         <= '0;
            k         <= '0;
            b         <= '0;
            mode_q    <= 1'b0;
            found     <= 1'b0;
            sol_count <= '0;
            for (int i = 0; i < DEPTH; i++) col[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        found     <= 1'b0;
                        sol_count <= '0;
                        state     <= INIT;
                    end
                end
                INIT: begin
                    r      <= '0;
                    k      <= '0;
                    col[0] <= '0;
                    state  <= CHECK;
                end
                CHECK: begin
                    if (k == r) begin
                        // Every earlier row has been compared: row r is safe.
                        if (r == LAST) begin
                            state <= SOLVED;
                        end else begin
                            col[r[W-1:0] + W'(1)] <= '0;
                            r <= r + (W + 1)'(1);
                            k <= '0;
                        end
                    end else if (conflict) begin
                        state <= ADVANCE;
                    end else begin
                        k <= k + (W + 1)'(1);
                    end
                end
                ADVANCE: begin
                    if ({1'b0, col_r} < LAST) begin
                        col[r[W-1:0]] <= col_r + W'(1);
                        k     <= '0;
                        state <= CHECK;
                    end else begin
                        state <= BACKTRACK;
                    end
                end
                BACKTRACK: begin
                    // Row r is out of columns; resume the previous row's scan.
                    if (r == '0) begin
                        state <= DONE;
                    end else begin
                        r     <= r - (W + 1)'(1);
                        state <= ADVANCE;
                    end
                end
                SOLVED: begin
                    found     <= 1'b1;
                    sol_count <= sat_inc(sol_count);
                    if (!mode_q) begin
                        b     <= '0;
                        state <= TRANSMIT;
                    end else begin
                        // Counting: reject this placement and keep searching.
                        state <= ADVANCE;
                    end
                end
                TRANSMIT: begin
                    if (out_ready) begin
                        if (b == LAST[W-1:0]) state <= DONE;
                        else b <= b + W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n_queen_solver.sv
// Bench for n_queen_solver: several board sizes instantiated side by side,
// each run compared against a software N-queens enumerator.
module tb_n_queen_solver;

    localparam int NI    = 8;
    localparam int LIMIT = 200000;

    logic clk = 1'b0;
    logic user_reset;
    logic [NI-1:0] st;
    logic mode;
    logic out_ready;

    always #5 clk = ~clk;

    logic [NI-1:0] rdy, bsy, dn, fnd, ov;
    logic [15:0]   sc [NI];
    logic [3:0]    od [NI];

    logic [15:0] sc0, sc1, sc2, sc3, sc4, sc5, sc6;
    logic [2:0]  sc7;
    logic [2:0]  od0, od2, od3, od7;
    logic [1:0]  od1, od4;
    logic [0:0]  od5, od6;

    // Instance order: N=8, 4, 5, 6, 3, 2, 1, and N=8 with a 3-bit counter.
    int nval [NI] = '{8, 4, 5, 6, 3, 2, 1, 8};

    n_queen_solver #(.N(8), .CW(16)) u0 (.clk(clk), .user_reset(user_reset), .start(st[0]), .mode(mode),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .found(fnd[0]), .sol_count(sc0),
        .out_valid(ov[0]), .out_data(od0), .out_ready(out_ready));
    n_queen_solver #(.N(4), .CW(16)) u1 (.clk(clk), .user_reset(user_reset), .start(st[1]), .mode(mode),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .found(fnd[1]), .sol_count(sc1),
        .out_valid(ov[1]), .out_data(od1), .out_ready(out_ready));
    n_queen_solver #(.N(5), .CW(16)) u2 (.clk(clk), .user_reset(user_reset), .start(st[2]), .mode(mode),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .found(fnd[2]), .sol_count(sc2),
        .out_valid(ov[2]), .out_data(od2), .out_ready(out_ready));
    n_queen_solver #(.N(6), .CW(16)) u3 (.clk(clk), .user_reset(user_reset), .start(st[3]), .mode(mode),
        .ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .found(fnd[3]), .sol_count(sc3),
        .out_valid(ov[3]), .out_data(od3), .out_ready(out_ready));
    n_queen_solver #(.N(3), .CW(16)) u4 (.clk(clk), .user_reset(user_reset), .start(st[4]), .mode(mode),
        .ready(rdy[4]), .busy(bsy[4]), .done(dn[4]), .found(fnd[4]), .sol_count(sc4),
        .out_valid(ov[4]), .out_data(od4), .out_ready(out_ready));
    n_queen_solver #(.N(2), .CW(16)) u5 (.clk(clk), .user_reset(user_reset), .start(st[5]), .mode(mode),
        .ready(rdy[5]), .busy(bsy[5]), .done(dn[5]), .found(fnd[5]), .sol_count(sc5),
        .out_valid(ov[5]), .out_data(od5), .out_ready(out_ready));
    n_queen_solver #(.N(1), .CW(16)) u6 (.clk(clk), .user_reset(user_reset), .start(st[6]), .mode(mode),
        .ready(rdy[6]), .busy(bsy[6]), .done(dn[6]), .found(fnd[6]), .sol_count(sc6),
        .out_valid(ov[6]), .out_data(od6), .out_ready(out_ready));
    n_queen_solver #(.N(8), .CW(3)) u7 (.clk(clk), .user_reset(user_reset), .start(st[7]), .mode(mode),
        .ready(rdy[7]), .busy(bsy[7]), .done(dn[7]), .found(fnd[7]), .sol_count(sc7),
        .out_valid(ov[7]), .out_data(od7), .out_ready(out_ready));

    assign sc[0] = sc0;  assign sc[1] = sc1;  assign sc[2] = sc2;  assign sc[3] = sc3;
    assign sc[4] = sc4;  assign sc[5] = sc5;  assign sc[6] = sc6;  assign sc[7] = 16'(sc7);
    assign od[0] = 4'(od0); assign od[1] = 4'(od1); assign od[2] = 4'(od2); assign od[3] = 4'(od3);
    assign od[4] = 4'(od4); assign od[5] = 4'(od5); assign od[6] = 4'(od6); assign od[7] = 4'(od7);

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: plain software enumeration of all N-queens placements,
    // rows filled top to bottom, columns tried in ascending order.
    int ref_cnt;
    int ref_sol [16];
    int got [16];

    task automatic ref_solve(input int n);
        int q [16];
        int row;
        bit ok;
        ref_cnt = 0;
        for (int i = 0; i < 16; i++) begin q[i] = 0; ref_sol[i] = 0; end
        row = 0;
        while (row >= 0) begin
            if (q[row] >= n) begin
                row--;
                if (row >= 0) q[row]++;
            end else begin
                ok = 1'b1;
                for (int j = 0; j < row; j++)
                    if (q[j] == q[row] || q[j] - q[row] == row - j || q[row] - q[j] == row - j) ok = 1'b0;
                if (!ok) begin
                    q[row]++;
                end else if (row == n - 1) begin
                    if (ref_cnt == 0) for (int i = 0; i < 16; i++) ref_sol[i] = q[i];
                    ref_cnt++;
                    q[row]++;
                end else begin
                    row++;
                    q[row] = 0;
                end
            end
        end
    endtask

    // One run on instance idx. stall: 0 = always ready, 1 = random, 2 = 1,0,0 pattern.
    task automatic run(input int idx, input bit m, input int stall);
        int n, beats, hs_cyc, ovc, pat, hold, done_cyc, exp_cnt, exp_beats;
        bit saw_done;
        n = nval[idx];
        ref_solve(n);
        if (m) exp_cnt = (idx == 7 && ref_cnt > 7) ? 7 : ref_cnt;
        else   exp_cnt = (ref_cnt > 0) ? 1 : 0;
        exp_beats = (!m && ref_cnt > 0) ? n : 0;
        for (int i = 0; i < 16; i++) got[i] = -1;

        hold = $urandom_range(1, 3);
        mode = m;
        st[idx] = 1'b1;
        @(negedge clk);
        check("start_busy", bsy[idx], 1'b1);
        check("start_ready", rdy[idx], 1'b0);
        check("start_found_clr", fnd[idx], 1'b0);
        check("start_cnt_clr", sc[idx], 0);
        repeat (hold - 1) @(negedge clk);
        st[idx] = 1'b0;
        mode = ~m;

        beats = 0; hs_cyc = -10; ovc = 0; pat = 0; saw_done = 1'b0; done_cyc = 0;
        for (int c = 0; c < LIMIT && !saw_done; c++) begin
            if (dn[idx]) begin
                saw_done = 1'b1;
                done_cyc = c;
            end else begin
                if (stall == 0)      out_ready = 1'b1;
                else if (stall == 1) out_ready = 1'($urandom_range(0, 1));
                else                 out_ready = (pat % 3 == 0);
                if (ov[idx]) begin
                    ovc++;
                    pat++;
                    if (beats < 16) check("beat_data", od[idx], ref_sol[beats]);
                    if (out_ready) begin
                        if (beats < 16) got[beats] = int'(od[idx]);
                        beats++;
                        hs_cyc = c;
                    end
                end
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        check("done_seen", saw_done, 1'b1);
        check("beats", beats, exp_beats);
        if (exp_beats == 0) check("no_valid", ovc, 0);
        else check("done_after_last_beat", done_cyc, hs_cyc + 1);
        check("found", fnd[idx], (ref_cnt > 0) ? 1 : 0);
        check("sol_count", sc[idx], exp_cnt);
        @(negedge clk);
        check("done_one_cycle", dn[idx], 1'b0);
        check("ready_after", rdy[idx], 1'b1);
        check("count_held", sc[idx], exp_cnt);
    endtask

    int tbl [8] = '{0, 4, 7, 5, 2, 6, 1, 3};
    int d0, d7, c0, c7, ovc2, ridx, rstall;
    bit rmode, seen;

    initial begin
        user_reset = 1'b1; st = '0; mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", rdy, 8'hFF);
        check("rst_busy", bsy, 8'h00);
        check("rst_done", dn, 8'h00);
        check("rst_found", fnd, 8'h00);
        check("rst_valid", ov, 8'h00);
        check("rst_count", sc[0], 0);
        check("rst_data", od[0], 0);
        user_reset = 1'b0;
        @(negedge clk);

        // N=8 first solution, always ready
        run(0, 1'b0, 0);
        for (int i = 0; i < 8; i++) check("n8_stream", got[i], tbl[i]);
        // Counting on small boards
        run(1, 1'b1, 0);
        check("n4_count", sc[1], 2);
        run(2, 1'b1, 0);
        check("n5_count", sc[2], 10);
        run(3, 1'b1, 0);
        check("n6_count", sc[3], 4);
        // N=4 stream under back-pressure
        run(1, 1'b0, 2);
        for (int i = 0; i < 4; i++) check("n4_stream", got[i], (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 0 : 2);
        // Degenerate boards
        run(4, 1'b0, 0); run(4, 1'b1, 0);
        run(5, 1'b0, 0); run(5, 1'b1, 1);
        run(6, 1'b0, 0);
        check("n1_beat", got[0], 0);
        run(6, 1'b1, 1);

        // Random runs (exhaustive N=8 is left to the long run below)
        for (int t = 0; t < 12; t++) begin
            ridx   = $urandom_range(0, 6);
            rmode  = (ridx == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            rstall = $urandom_range(0, 2);
            run(ridx, rmode, rstall);
        end

        // Reset in the middle of a search
        mode = 1'b1; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_search_busy", bsy[0], 1'b1);
        user_reset = 1'b1;
        #1;
        check("abort_search_ready", rdy[0], 1'b1);
        check("abort_search_busy", bsy[0], 1'b0);
        check("abort_search_count", sc[0], 0);
        @(negedge clk);
        user_reset = 1'b0;
        @(negedge clk);

        // Reset while stalled in the output stream
        mode = 1'b0; out_ready = 1'b0; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            if (ov[0]) seen = 1'b1;
            else @(negedge clk);
        end
        check("stream_reached", seen, 1'b1);
        check("stream_found", fnd[0], 1'b1);
        user_reset = 1'b1;
        #1;
        check("abort_tx_valid", ov[0], 1'b0);
        check("abort_tx_data", od[0], 0);
        check("abort_tx_found", fnd[0], 1'b0);
        check("abort_tx_count", sc[0], 0);
        check("abort_tx_ready", rdy[0], 1'b1);
        @(negedge clk);
        user_reset = 1'b0;
        @(negedge clk);

        // Exhaustive N=8 on both widths together; instance 0 also sees a
        // start pulse and a mode flip mid-run, which must change nothing.
        ref_solve(8);
        mode = 1'b1; out_ready = 1'b1; st[0] = 1'b1; st[7] = 1'b1;
        @(negedge clk);
        st = '0;
        d0 = 0; d7 = 0; c0 = -1; c7 = -2; ovc2 = 0;
        for (int c = 0; c < LIMIT && (d0 == 0 || d7 == 0); c++) begin
            if (c == 100) begin st[0] = 1'b1; mode = 1'b0; end
            if (c == 101) st[0] = 1'b0;
            if (dn[0]) begin d0++; c0 = c; end
            if (dn[7]) begin d7++; c7 = c; end
            if (ov[0] || ov[7]) ovc2++;
            @(negedge clk);
        end
        repeat (5) begin
            if (dn[0]) d0++;
            if (dn[7]) d7++;
            @(negedge clk);
        end
        check("n8_done_once", d0, 1);
        check("n8_sat_done_once", d7, 1);
        check("n8_start_ignored", c0, c7);
        check("n8_no_valid", ovc2, 0);
        check("n8_count", sc[0], ref_cnt);
        check("n8_count_92", sc[0], 92);
        check("n8_sat_count", sc[7], (ref_cnt > 7) ? 7 : ref_cnt);
        check("n8_found", fnd[0], 1'b1);
        check("n8_sat_found", fnd[7], 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/n_queen_solver.md
# n_queen_solver

Parametrised N-queens search engine: a self-contained controller plus datapath that replaces the fixed 8-queen controller/datapath pair with a generic backtracking solver. The board size is a parameter. A per-run mode selects between stopping at the first solution and streaming it, or exhausting the search space and reporting the solution count. The block sits behind the same start/ready/done handshake as the 8-queen unit and adds a back-pressured output stream.

## Interface
- N, 8: board size; legal range 1..16.
- W, clog2(N) (minimum 1): width of row/column indices.
- CW, 16: width of the solution counter.

- clk  in  1  system clock, rising edge.
- user_reset  in  1  asynchronous, active-high reset. Forces IDLE and clears all registers.
- start  in  1  sampled only in IDLE. High for one or more cycles launches a run.
- mode  in  1  latched with start. 0 = first-solution-and-stream; 1 = count-all.
- ready  out  1  high exactly while in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- found  out  1  at least one solution found in the last run. Held until the next start.
- sol_count  out  CW  solutions found in the last run; saturates at 2^CW-1. Held until the next start.
- out_valid  out  1  high in TRANSMIT.
- out_data  out  W  column of the queen in the row indexed by the beat number.
- out_ready  in  1  consumer accepts a beat when out_valid and out_ready are both high.

## Operation
- Registers:
  - col[0..N-1] (W bits each)
  - row index r and compare index k (W+1 bits each)
  - beat index b
  - mode_q, found, sol_count
- States: IDLE, INIT, CHECK, ADVANCE, BACKTRACK, SOLVED, TRANSMIT, DONE.
- IDLE:
  - start=1 moves to INIT and latches mode_q.
  - found and sol_count are cleared on the start edge.
- INIT: r=0, k=0, col[0]=0, then CHECK.
- CHECK: one comparison per cycle.
  - If k==r, the row is safe:
    - r==N-1 goes to SOLVED.
    - Otherwise r<=r+1, col[r+1]<=0, k<=0, stay in CHECK.
  - Else a conflict exists if col[k]==col[r] or |col[k]-col[r]|==r-k; a conflict goes to ADVANCE.
  - No conflict: k<=k+1, stay in CHECK.
- ADVANCE:
  - If col[r]<N-1: col[r]<=col[r]+1, k<=0, go to CHECK.
  - Else go to BACKTRACK.
- BACKTRACK:
  - If r==0, the search is exhausted: go to DONE.
  - Else r<=r-1, go to ADVANCE. Repeated BACKTRACK/ADVANCE pairs unwind multiple saturated rows.
- SOLVED:
  - found<=1.
  - sol_count<=sol_count+1, saturating.
  - If mode_q==0: b<=0, go to TRANSMIT.
  - If mode_q==1: go to ADVANCE, treating the current placement as rejected.
- TRANSMIT:
  - out_data=col[b].
  - On handshake: if b==N-1 go to DONE, else b<=b+1.
  - Without out_ready, state, out_valid and out_data hold.
- DONE: done=1, then IDLE.
- Degenerate sizes:
  - N=1 yields one solution, data 0.
  - N=2 and N=3 yield found=0, sol_count=0.

## Timing
- Reset values:
  - state IDLE, so ready=1, busy=0.
  - done=0, found=0, sol_count=0, out_valid=0, out_data=0.
  - all col, r, k, b = 0.
- Reset asserted mid-search or mid-TRANSMIT aborts immediately. The next start runs from scratch.
- start is ignored outside IDLE. A mode change during a run has no effect.
- ready, busy, done and out_valid decode from the current state. sol_count and found are registered and update on the cycle after SOLVED.
- Latency from start to the first CHECK is 2 cycles (IDLE→INIT→CHECK).
- Each CHECK cycle evaluates one pair. Placing row r costs r+1 CHECK cycles per candidate column.
- TRANSMIT takes at least N cycles; each stalled cycle adds one.
- done fires exactly once per run, on the cycle after the last accepted beat (mode 0) or after exhaustion (mode 1, or mode 0 with no solution).
- sol_count is stable and valid when done is high.

## Test plan
- N=8, mode 0, out_ready=1: stream 0,4,7,5,2,6,1,3 on consecutive beats -> found=1, sol_count=1, done one cycle after the eighth beat.
- N=8, mode 1: no out_valid ever -> done pulse with sol_count=92, found=1. Repeat N=4 -> 2, N=5 -> 10, N=6 -> 4.
- N=4, mode 0, out_ready toggling 1,0,0,1,...: beats 1,3,0,2 each held stable while stalled -> exactly 4 handshakes, then done.
- N=3 and N=2, both modes -> done with found=0, sol_count=0, no out_valid. N=1, mode 0 -> single beat 0, sol_count=1.
- Assert user_reset during CHECK, then during TRANSMIT -> outputs return to reset values within the same cycle (asynchronous). Restart N=8 mode 1 -> 92.
- CW=3, N=8, mode 1 -> sol_count saturates at 7. start pulsed while busy -> ignored; the run completes with one done.
